// File: rtl/t07_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data; T07_ARB_TIMEOUT_EN adds a wait timeout.
// Latency: request cycle N -> ext_rwi cycle N+1 -> earliest ack N+1 -> done pulse N+2.
// Backpressure: freeze holds the CPU while a request is pending in IDLE or an access is issued.
module t07_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack,
  output logic [1:0]        ext_rwi,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              fetch_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              freeze,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE_D, ISSUE_F, DONE} state_t;

  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_READ  = 2'b01;
  localparam logic [1:0] RWI_WRITE = 2'b10;
  localparam logic [1:0] RWI_FETCH = 2'b11;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = fetch was granted last
  logic [1:0]        ext_rwi_q, ext_rwi_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fetch_done_q, fetch_done_d;
  logic              data_done_q, data_done_d;
  logic              err_q, err_d;
  logic              data_pend;
  logic              issuing;
  logic              timeout_hit;

  assign data_pend = data_read | data_write;
  assign issuing   = (state_q == ISSUE_D) || (state_q == ISSUE_F);

`ifdef T07_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counter is zero whenever not issuing, so it is already clear on entry.
  always_comb begin
    wait_cnt_d = '0;
    if (issuing && !ext_ack) wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ext_rwi_d    = ext_rwi_q;
    ext_addr_d   = ext_addr_q;
    ext_wdata_d  = ext_wdata_q;
    instr_d      = instr_q;
    rdata_d      = rdata_q;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_pend && (!fetch_req || last_grant_q)) begin
          state_d      = ISSUE_D;
          last_grant_d = 1'b0;
          ext_addr_d   = data_addr;
          ext_wdata_d  = data_wdata;
          ext_rwi_d    = data_write ? RWI_WRITE : RWI_READ;
        end else if (fetch_req) begin
          state_d      = ISSUE_F;
          last_grant_d = 1'b1;
          ext_addr_d   = fetch_addr;
          ext_wdata_d  = data_wdata;
          ext_rwi_d    = RWI_FETCH;
        end
      end
      ISSUE_D, ISSUE_F: begin
        // An ack coinciding with the limit wins; a timed-out read returns zero.
        if (ext_ack || timeout_hit) begin
          state_d   = DONE;
          ext_rwi_d = RWI_IDLE;
          err_d     = !ext_ack;
          if (state_q == ISSUE_F) begin
            fetch_done_d = 1'b1;
            instr_d      = ext_ack ? ext_rdata : '0;
          end else begin
            data_done_d = 1'b1;
            if (ext_rwi_q == RWI_READ) rdata_d = ext_ack ? ext_rdata : '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ext_rwi_q    <= RWI_IDLE;
      ext_addr_q   <= '0;
      ext_wdata_q  <= '0;
      instr_q      <= '0;
      rdata_q      <= '0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ext_rwi_q    <= ext_rwi_d;
      ext_addr_q   <= ext_addr_d;
      ext_wdata_q  <= ext_wdata_d;
      instr_q      <= instr_d;
      rdata_q      <= rdata_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      err_q        <= err_d;
    end
  end

  assign ext_rwi    = ext_rwi_q;
  assign ext_addr   = ext_addr_q;
  assign ext_wdata  = ext_wdata_q;
  assign instr_out  = instr_q;
  assign data_rdata = rdata_q;
  assign fetch_done = fetch_done_q;
  assign data_done  = data_done_q;
  assign err        = err_q;
  assign freeze     = issuing || ((state_q == IDLE) && (fetch_req || data_pend));

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Directed bench for t07_mem_arbiter; build with T07_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_t07_mem_arbiter;

  logic        clk;
  logic        nrst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;
  logic [1:0]  ext_rwi;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] instr_out;
  logic        fetch_done;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        freeze;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  t07_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_read(data_read), .data_write(data_write),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .ext_rwi(ext_rwi), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .instr_out(instr_out), .fetch_done(fetch_done),
    .data_rdata(data_rdata), .data_done(data_done),
    .freeze(freeze), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  rr_rwi  [4];
  logic [31:0] rr_data [4];

  initial begin
    rr_rwi  = '{2'b01, 2'b11, 2'b01, 2'b11};
    rr_data = '{32'hA0000001, 32'hB0000002, 32'hA0000003, 32'hB0000004};
    nrst = 1'b0; fetch_req = 1'b0; fetch_addr = '0; data_read = 1'b0; data_write = 1'b0;
    data_addr = '0; data_wdata = '0; ext_rdata = '0; ext_ack = 1'b0;
    tick(); tick();
    chk("rst_rwi", 32'(ext_rwi), 32'h0);
    chk("rst_addr", ext_addr, 32'h0);
    chk("rst_wdata", ext_wdata, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_rdata", data_rdata, 32'h0);
    chk("rst_pulses", {29'b0, fetch_done, data_done, err}, 32'h0);
    chk("rst_freeze", 32'(freeze), 32'h0);
    nrst = 1'b1;
    tick();

    // Single load
    data_read = 1'b1; data_addr = 32'h4;
    #1 chk("ld_freeze_idle", 32'(freeze), 32'h1);
    tick();
    chk("ld_rwi", 32'(ext_rwi), 32'h1);
    chk("ld_addr", ext_addr, 32'h4);
    chk("ld_freeze", 32'(freeze), 32'h1);
    ext_ack = 1'b1; ext_rdata = 32'h99999999;
    tick();
    chk("ld_done", 32'(data_done), 32'h1);
    chk("ld_rdata", data_rdata, 32'h99999999);
    chk("ld_rwi_idle", 32'(ext_rwi), 32'h0);
    chk("ld_freeze_done", 32'(freeze), 32'h0);
    data_read = 1'b0; ext_ack = 1'b0;
    tick();
    chk("ld_done_1cyc", 32'(data_done), 32'h0);

    // Single store
    data_write = 1'b1; data_addr = 32'h8; data_wdata = 32'h87654321;
    tick();
    chk("st_rwi", 32'(ext_rwi), 32'h2);
    chk("st_addr", ext_addr, 32'h8);
    chk("st_wdata", ext_wdata, 32'h87654321);
    ext_ack = 1'b1; ext_rdata = 32'h13579BDF;
    tick();
    chk("st_done", 32'(data_done), 32'h1);
    chk("st_rdata_kept", data_rdata, 32'h99999999);
    data_write = 1'b0; ext_ack = 1'b0;
    tick();

    // Simultaneous fetch and load after reset: data first
    nrst = 1'b0; #1 nrst = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h100; data_read = 1'b1; data_addr = 32'h10;
    tick();
    chk("both_first_rwi", 32'(ext_rwi), 32'h1);
    chk("both_first_addr", ext_addr, 32'h10);
    ext_ack = 1'b1; ext_rdata = 32'h11111111;
    tick();
    chk("both_first_done", 32'(data_done), 32'h1);
    data_read = 1'b0; ext_ack = 1'b0;
    tick();
    chk("both_idle_freeze", 32'(freeze), 32'h1);
    tick();
    chk("both_second_rwi", 32'(ext_rwi), 32'h3);
    chk("both_second_addr", ext_addr, 32'h100);
    ext_ack = 1'b1; ext_rdata = 32'h00A00093;
    tick();
    chk("fetch_done", 32'(fetch_done), 32'h1);
    chk("fetch_no_data_done", 32'(data_done), 32'h0);
    chk("instr_out", instr_out, 32'h00A00093);
    fetch_req = 1'b0; ext_ack = 1'b0;
    tick();

    // Continuous round-robin, ack two cycles after issue
    data_read = 1'b1; data_addr = 32'h40; fetch_req = 1'b1; fetch_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_freeze_idle", 32'(freeze), 32'h1);
      tick();
      chk("rr_rwi", 32'(ext_rwi), 32'(rr_rwi[k]));
      tick();
      chk("rr_rwi_hold", 32'(ext_rwi), 32'(rr_rwi[k]));
      chk("rr_freeze_issue", 32'(freeze), 32'h1);
      ext_ack = 1'b1; ext_rdata = rr_data[k];
      tick();
      chk("rr_done_pulses", {30'b0, fetch_done, data_done}, (rr_rwi[k] == 2'b11) ? 32'h2 : 32'h1);
      chk("rr_freeze_done", 32'(freeze), 32'h0);
      if (rr_rwi[k] == 2'b11) chk("rr_instr", instr_out, rr_data[k]);
      else                    chk("rr_rdata", data_rdata, rr_data[k]);
      ext_ack = 1'b0;
      tick();
    end
    data_read = 1'b0; fetch_req = 1'b0;
    tick();

    // Reset while a fetch is issued, then a stray ack
    fetch_req = 1'b1; fetch_addr = 32'h300;
    tick();
    chk("abort_rwi_pre", 32'(ext_rwi), 32'h3);
    nrst = 1'b0; fetch_req = 1'b0;
    #1 chk("abort_rwi", 32'(ext_rwi), 32'h0);
    chk("abort_freeze", 32'(freeze), 32'h0);
    tick();
    nrst = 1'b1; ext_ack = 1'b1; ext_rdata = 32'hDEADBEEF;
    tick();
    chk("stray_no_fetch_done", 32'(fetch_done), 32'h0);
    chk("stray_instr", instr_out, 32'h0);
    chk("stray_rwi", 32'(ext_rwi), 32'h0);
    ext_ack = 1'b0;
    data_read = 1'b1; data_addr = 32'h20;
    tick();
    chk("post_abort_rwi", 32'(ext_rwi), 32'h1);
    ext_ack = 1'b1; ext_rdata = 32'h55555555;
    tick();
    chk("post_abort_rdata", data_rdata, 32'h55555555);
    data_read = 1'b0; ext_ack = 1'b0;
    tick();

    // Load with no ack
    data_read = 1'b1; data_addr = 32'h24;
    tick();
`ifdef T07_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_err", 32'(err), 32'h0);
      chk("to_wait_rwi", 32'(ext_rwi), 32'h1);
    end
    tick();
    chk("to_err", 32'(err), 32'h1);
    chk("to_done", 32'(data_done), 32'h1);
    chk("to_rdata", data_rdata, 32'h0);
    chk("to_rwi", 32'(ext_rwi), 32'h0);
    data_read = 1'b0;
    tick();
    chk("to_err_1cyc", 32'(err), 32'h0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_rwi", 32'(ext_rwi), 32'h1);
    chk("nto_err", 32'(err), 32'h0);
    chk("nto_done", 32'(data_done), 32'h0);
    chk("nto_freeze", 32'(freeze), 32'h1);
    ext_ack = 1'b1; ext_rdata = 32'h12345678;
    tick();
    chk("nto_late_done", 32'(data_done), 32'h1);
    chk("nto_late_rdata", data_rdata, 32'h12345678);
    data_read = 1'b0; ext_ack = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
